i2c_e2prom_slave: RTL

I2C_E2PROM_SLAVE -- requirements
Module: i2c_e2prom_slave

---
 rtl/i2c_e2prom_slave_if.sv | 22 ++
 rtl/i2c_e2prom_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_e2prom_slave_if.sv
// Write-status bundle of the I2C EEPROM slave: busy flag and the
// strobe/address/data of the most recently committed byte.
interface i2c_e2prom_slave_if;
   logic       o_Busy;
   logic       o_Wr_Strobe;
   logic [7:0] o_Wr_Addr;
   logic [7:0] o_Wr_Data;

   modport slave (
      output o_Busy,
      output o_Wr_Strobe,
      output o_Wr_Addr,
      output o_Wr_Data
   );

   modport master (
      input o_Busy,
      input o_Wr_Strobe,
      input o_Wr_Addr,
      input o_Wr_Data
   );
endinterface

// File: rtl/i2c_e2prom_slave.sv
// I2C EEPROM-style slave: 256x8 memory behind an auto-incrementing
// pointer; byte writes plus random and current-address reads.
module i2c_e2prom_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic              i_clk10MHz,
   input  logic              i_RST_n,
   input  logic              i_I2C_SCL,
   inout  wire               io_I2C_SDA,
   i2c_e2prom_slave_if.slave wr_if
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_REG,
      S_REG_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_ACK,
      S_WAIT_STOP
   } state_t;

   state_t     state, state_nxt;
   logic       scl_s1, scl_s2, scl_d;
   logic       sda_s1, sda_s2, sda_d;
   logic       scl_rise, scl_fall;
   logic       start_det, stop_det;
   logic [7:0] shift, shift_nxt;
   logic [7:0] ptr, ptr_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       sda_oe, sda_oe_nxt;
   logic       busy, busy_nxt;
   logic       strobe, strobe_nxt;
   logic [7:0] waddr, waddr_nxt;
   logic [7:0] wdata, wdata_nxt;
   logic [7:0] rd_byte;
   logic       mem_we;
   logic [7:0] mem [256];

   assign io_I2C_SDA = sda_oe ? 1'b0 : 1'bz;

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign rd_byte   = mem[ptr];

   assign wr_if.o_Busy      = busy;
   assign wr_if.o_Wr_Strobe = strobe;
   assign wr_if.o_Wr_Addr   = waddr;
   assign wr_if.o_Wr_Data   = wdata;

   always_ff @(posedge i_clk10MHz) begin
      if (!i_RST_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         start_det: state_nxt = S_ADDR;
         stop_det:  state_nxt = S_IDLE;
         default: begin
            case (state)
               S_ADDR:
                  if (scl_rise && cnt == 3'd7)
                     state_nxt = (shift[6:0] == SLAVE_ADDR) ?
                                 S_ADDR_ACK : S_WAIT_STOP;
               S_ADDR_ACK:
                  if (scl_fall && sda_oe)
                     state_nxt = shift[0] ? S_RDATA : S_REG;
               S_REG:
                  if (scl_rise && cnt == 3'd7) state_nxt = S_REG_ACK;
               S_REG_ACK:
                  if (scl_fall && sda_oe) state_nxt = S_WDATA;
               S_WDATA:
                  if (scl_rise && cnt == 3'd7) state_nxt = S_WDATA_ACK;
               S_WDATA_ACK:
                  if (scl_fall && sda_oe) state_nxt = S_WDATA;
               S_RDATA:
                  if (scl_fall && cnt == 3'd7) state_nxt = S_RDATA_ACK;
               S_RDATA_ACK:
                  if (scl_rise && sda_s2)
                     state_nxt = S_WAIT_STOP;
                  else if (scl_fall && cnt == 3'd1)
                     state_nxt = S_RDATA;
               default: ;
            endcase
         end
      endcase
   end

   // ACK states use sda_oe to tell the driving fall from the releasing fall
   always_comb begin
      shift_nxt  = shift;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      sda_oe_nxt = sda_oe;
      busy_nxt   = busy;
      strobe_nxt = 1'b0;
      waddr_nxt  = waddr;
      wdata_nxt  = wdata;
      mem_we     = 1'b0;
      unique case (1'b1)
         start_det: begin
            cnt_nxt    = 3'd0;
            sda_oe_nxt = 1'b0;
         end
         stop_det: begin
            cnt_nxt    = 3'd0;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
         end
         default: begin
            case (state)
               S_ADDR, S_REG, S_WDATA:
                  if (scl_rise) begin
                     shift_nxt = {shift[6:0], sda_s2};
                     cnt_nxt   = cnt + 3'd1;
                  end
               S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK:
                  if (scl_fall && !sda_oe) begin
                     sda_oe_nxt = 1'b1;
                     if (state == S_ADDR_ACK) busy_nxt = 1'b1;
                     if (state == S_REG_ACK) ptr_nxt = shift;
                     if (state == S_WDATA_ACK) begin
                        mem_we     = i_RST_n;
                        strobe_nxt = 1'b1;
                        waddr_nxt  = ptr;
                        wdata_nxt  = shift;
                        ptr_nxt    = ptr + 8'd1;
                     end
                  end else if (scl_fall) begin
                     sda_oe_nxt = 1'b0;
                     cnt_nxt    = 3'd0;
                     if (state == S_ADDR_ACK && shift[0]) begin
                        shift_nxt  = rd_byte;
                        ptr_nxt    = ptr + 8'd1;
                        sda_oe_nxt = ~rd_byte[7];
                     end
                  end
               S_RDATA:
                  if (scl_fall && cnt == 3'd7) begin
                     sda_oe_nxt = 1'b0;
                     cnt_nxt    = 3'd0;
                  end else if (scl_fall) begin
                     cnt_nxt    = cnt + 3'd1;
                     shift_nxt  = {shift[6:0], 1'b0};
                     sda_oe_nxt = ~shift[6];
                  end
               S_RDATA_ACK:
                  if (scl_rise && !sda_s2) begin
                     cnt_nxt = 3'd1;
                  end else if (scl_fall && cnt == 3'd1) begin
                     cnt_nxt    = 3'd0;
                     shift_nxt  = rd_byte;
                     ptr_nxt    = ptr + 8'd1;
                     sda_oe_nxt = ~rd_byte[7];
                  end
               default: ;
            endcase
         end
      endcase
   end

   always_ff @(posedge i_clk10MHz) begin
      if (!i_RST_n) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_d  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_d  <= 1'b1;
         shift  <= 8'h00;
         ptr    <= 8'h00;
         cnt    <= 3'd0;
         sda_oe <= 1'b0;
         busy   <= 1'b0;
         strobe <= 1'b0;
         waddr  <= 8'h00;
         wdata  <= 8'h00;
      end else begin
         scl_s1 <= i_I2C_SCL;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
         sda_s1 <= io_I2C_SDA;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
         shift  <= shift_nxt;
         ptr    <= ptr_nxt;
         cnt    <= cnt_nxt;
         sda_oe <= sda_oe_nxt;
         busy   <= busy_nxt;
         strobe <= strobe_nxt;
         waddr  <= waddr_nxt;
         wdata  <= wdata_nxt;
      end
   end

   // Memory keeps its contents across reset
   always_ff @(posedge i_clk10MHz) begin
      if (mem_we) mem[ptr] <= shift;
   end

endmodule
